// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60Hz VGA raster timing generator
//
// Derives a CLK/2 pixel clock and walks the raster one pixel per two CLK
// cycles. hs/vs/blank are registered from the next counter values, so they
// always describe the DrawX/DrawY presented in the same cycle.
//
// Optional feature: define VGA_FRAME_CNT_EN to enable the 8-bit frame counter;
// without it frame_cnt is tied to zero.
//
// Ports:
//   CLK          in   1   system clock (50 MHz), the only clock
//   Reset        in   1   asynchronous, active-high reset
//   VGA_clk      out  1   pixel clock, CLK/2, registered
//   hs           out  1   horizontal sync, active low
//   vs           out  1   vertical sync, active low
//   blank        out  1   1 = visible region, 0 = blanking
//   sync         out  1   composite sync to DAC, constant 0
//   DrawX        out  10  current pixel column
//   DrawY        out  10  current line
//   frame_start  out  1   one-CLK pulse on the first cycle at (0,0) after a wrap
//   frame_cnt    out  8   frame counter (zero unless VGA_FRAME_CNT_EN)

module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       CLK,
  input  logic       Reset,
  output logic       VGA_clk,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       pix_phase;
  logic       pix_en;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       frame_wrap;
  logic       hs_next;
  logic       vs_next;
  logic       blank_next;

  // Pixel advances on the edge where pix_phase falls, so each coordinate is
  // stable across the following VGA_clk rising edge.
  assign pix_en  = pix_phase;
  assign VGA_clk = pix_phase;
  assign sync    = 1'b0;

  always_comb begin
    x_next     = DrawX;
    y_next     = DrawY;
    frame_wrap = 1'b0;
    if (pix_en) begin
      if (DrawX == H_LAST) begin
        x_next = 10'd0;
        if (DrawY == V_LAST) begin
          y_next     = 10'd0;
          frame_wrap = 1'b1;
        end else begin
          y_next = DrawY + 10'd1;
        end
      end else begin
        x_next = DrawX + 10'd1;
      end
    end
  end

  // Decoded from the next counter values so the registered flags line up
  // with the registered counters.
  always_comb begin
    hs_next    = !((x_next >= HS_START) && (x_next < HS_END));
    vs_next    = !((y_next >= VS_START) && (y_next < VS_END));
    blank_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pix_phase   <= 1'b0;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pix_phase   <= ~pix_phase;
      DrawX       <= x_next;
      DrawY       <= y_next;
      hs          <= hs_next;
      vs          <= vs_next;
      blank       <= blank_next;
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Steps on the same edge that raises frame_start; wraps naturally mod 256.
  logic [7:0] frame_cnt_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      frame_cnt_q <= 8'h00;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'h01;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'h00;
`endif

endmodule
